// File: rtl/picobello_pkg.sv
// picobello_pkg: shared address-map, tile-id and multicast decode types.
package picobello_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
    } axi_cfg_t;

    localparam axi_cfg_t    AxiCfgN      = '{AddrWidth: 48};
    localparam int unsigned PkgAddrWidth = AxiCfgN.AddrWidth;
    localparam int unsigned SamNumRules  = 4;
    localparam int unsigned XWidth       = 3;
    localparam int unsigned YWidth       = 3;
    localparam int unsigned SelWidth     = 6;

    typedef struct packed {
        logic              port_id;
        logic [YWidth-1:0] y;
        logic [XWidth-1:0] x;
    } id_t;

    typedef struct packed {
        logic [SelWidth-1:0] offset;
        logic [SelWidth-1:0] len;
    } mask_sel_t;

    typedef struct packed {
        id_t       id;
        mask_sel_t mask_x;
        mask_sel_t mask_y;
    } sam_idx_t;

    typedef struct packed {
        sam_idx_t                idx;
        logic [PkgAddrWidth-1:0] start_addr;
        logic [PkgAddrWidth-1:0] end_addr;
    } sam_multicast_rule_t;

    typedef enum logic [1:0] {
        ERR_OK            = 2'd0,
        ERR_NO_MATCH      = 2'd1,
        ERR_ILLEGAL_MCAST = 2'd2
    } mcast_dec_err_e;

    // Rule 0 is a multicast-capable tile window, rule 1 a unicast-only one; the rest are empty.
    localparam sam_multicast_rule_t SamMcast [SamNumRules] = '{
        '{idx: '{id: '{port_id: 1'b0, y: 3'd0, x: 3'd1},
                 mask_x: '{offset: 6'd20, len: 6'd2},
                 mask_y: '{offset: 6'd18, len: 6'd2}},
          start_addr: PkgAddrWidth'(32'h2000_0000), end_addr: PkgAddrWidth'(32'h2004_0000)},
        '{idx: '{id: '{port_id: 1'b0, y: 3'd3, x: 3'd0}, mask_x: '0, mask_y: '0},
          start_addr: PkgAddrWidth'(32'h7000_0000), end_addr: PkgAddrWidth'(32'h7010_0000)},
        '{default: '0},
        '{default: '0}
    };

endpackage

// File: rtl/pb_mcast_route_decoder_sam_match.sv
// pb_sam_match: combinational address-map lookup returning the lowest matching rule index.
module pb_sam_match #(
    parameter int unsigned NumRules  = 4,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdxWidth  = 2
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [AddrWidth-1:0] start_i [NumRules],
    input  logic [AddrWidth-1:0] end_i   [NumRules],
    output logic [IdxWidth-1:0]  idx_o,
    output logic                 hit_o
);

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (addr_i >= start_i[i] && addr_i < end_i[i]) begin
                hit_o = 1'b1;
                idx_o = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/pb_mcast_route_decoder.sv
// pb_mcast_route_decoder: two-stage multicast route decoder (S1 rule match, S2 id/mask/error).
// Mask extraction and illegal-multicast detection are enabled by PB_MCAST_DECODE_EN.
module pb_mcast_route_decoder
    import picobello_pkg::*;
#(
    parameter int unsigned NumRules  = SamNumRules,
    parameter int unsigned AddrWidth = AxiCfgN.AddrWidth,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  sam_multicast_rule_t    sam_i [NumRules],
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AddrWidth-1:0]   in_addr_i,
    input  logic [AddrWidth-1:0]   in_mask_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output id_t                    out_id_o,
    output logic [XWidth-1:0]      out_mask_x_o,
    output logic [YWidth-1:0]      out_mask_y_o,
    output mcast_dec_err_e         out_err_o,
    output logic [CntWidth-1:0]    err_cnt_o
);

    localparam int unsigned IdxWidth = NumRules > 1 ? $clog2(NumRules) : 1;

    logic [AddrWidth-1:0] start_addr [NumRules];
    logic [AddrWidth-1:0] end_addr   [NumRules];
    logic [IdxWidth-1:0]  match_idx, s1_idx_q;
    logic                 match_hit, s1_hit_q, s1_valid_q, s2_valid_q, s1_advance, accept;
    sam_idx_t             rule;
    id_t                  id_d, id_q;
    logic [XWidth-1:0]    mask_x_d, mask_x_q;
    logic [YWidth-1:0]    mask_y_d, mask_y_q;
    mcast_dec_err_e       err_d, err_q;
    logic [CntWidth-1:0]  cnt_q;

    always_comb begin
        for (int i = 0; i < NumRules; i++) begin
            start_addr[i] = AddrWidth'(sam_i[i].start_addr);
            end_addr[i]   = AddrWidth'(sam_i[i].end_addr);
        end
    end

    pb_sam_match #(
        .NumRules (NumRules),
        .AddrWidth(AddrWidth),
        .IdxWidth (IdxWidth)
    ) i_sam_match (
        .addr_i (in_addr_i),
        .start_i(start_addr),
        .end_i  (end_addr),
        .idx_o  (match_idx),
        .hit_o  (match_hit)
    );

    assign s1_advance = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_advance;
    assign accept     = in_valid_i && in_ready_o;
    assign rule       = sam_i[s1_idx_q].idx;
    assign id_d       = s1_hit_q ? rule.id : '0;

`ifdef PB_MCAST_DECODE_EN
    logic [AddrWidth-1:0] s1_mask_q;
    logic [XWidth-1:0]    sel_x;
    logic [YWidth-1:0]    sel_y;
    logic                 illegal;

    assign sel_x   = XWidth'((s1_mask_q >> rule.mask_x.offset) & ~({AddrWidth{1'b1}} << rule.mask_x.len));
    assign sel_y   = YWidth'((s1_mask_q >> rule.mask_y.offset) & ~({AddrWidth{1'b1}} << rule.mask_y.len));
    // A rule with no mask fields is unicast-only; any multicast bits to it are illegal.
    assign illegal = rule.mask_x.len == '0 && rule.mask_y.len == '0 && s1_mask_q != '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) s1_mask_q <= '0;
        else if (accept) s1_mask_q <= in_mask_i;
    end

    always_comb begin
        err_d    = !s1_hit_q ? ERR_NO_MATCH : illegal ? ERR_ILLEGAL_MCAST : ERR_OK;
        mask_x_d = (s1_hit_q && !illegal) ? sel_x : '0;
        mask_y_d = (s1_hit_q && !illegal) ? sel_y : '0;
    end
`else
    logic unused_mcast;

    assign unused_mcast = ^{in_mask_i, rule.mask_x, rule.mask_y};

    always_comb begin
        err_d    = s1_hit_q ? ERR_OK : ERR_NO_MATCH;
        mask_x_d = '0;
        mask_y_d = '0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            id_q       <= '0;
            mask_x_q   <= '0;
            mask_y_q   <= '0;
            err_q      <= ERR_OK;
            cnt_q      <= '0;
        end else begin
            if (in_ready_o) s1_valid_q <= in_valid_i;
            if (accept) begin
                s1_hit_q <= match_hit;
                s1_idx_q <= match_idx;
            end
            if (s1_advance) s2_valid_q <= s1_valid_q;
            if (s1_valid_q && s1_advance) begin
                id_q     <= id_d;
                mask_x_q <= mask_x_d;
                mask_y_q <= mask_y_d;
                err_q    <= err_d;
            end
            if (s2_valid_q && out_ready_i && err_q != ERR_OK && cnt_q != '1) cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_id_o     = id_q;
    assign out_mask_x_o = mask_x_q;
    assign out_mask_y_o = mask_y_q;
    assign out_err_o    = err_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_pb_mcast_route_decoder.sv
// tb_pb_mcast_route_decoder: directed bench for pb_mcast_route_decoder, both PB_MCAST_DECODE_EN builds.
module tb_pb_mcast_route_decoder;
    import picobello_pkg::*;

    localparam int unsigned AW = AxiCfgN.AddrWidth;
`ifdef PB_MCAST_DECODE_EN
    localparam bit En = 1'b1;
`else
    localparam bit En = 1'b0;
`endif

    logic                clk_i = 1'b0, rst_ni = 1'b0;
    logic                in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic                in_ready_o, out_valid_o;
    logic [AW-1:0]       in_addr_i = '0, in_mask_i = '0;
    id_t                 out_id_o;
    logic [XWidth-1:0]   out_mask_x_o;
    logic [YWidth-1:0]   out_mask_y_o;
    mcast_dec_err_e      out_err_o;
    logic [2:0]          err_cnt_o;
    sam_multicast_rule_t sam_tbl [SamNumRules];
    int                  n_tests = 0, n_fail = 0;
    int                  first_c, last_c;
    logic                seen;

    assign sam_tbl = SamMcast;
    always #5 clk_i = ~clk_i;

    pb_mcast_route_decoder #(.CntWidth(3)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sam_i       (sam_tbl),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_addr_i   (in_addr_i),
        .in_mask_i   (in_mask_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_id_o    (out_id_o),
        .out_mask_x_o(out_mask_x_o),
        .out_mask_y_o(out_mask_y_o),
        .out_err_o   (out_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    function automatic logic [31:0] obs();
        return 32'({out_valid_o, out_id_o, out_mask_x_o, out_mask_y_o, out_err_o});
    endfunction

    function automatic logic [31:0] ex(input int x, input int y, input int mx, input int my, input logic [1:0] e);
        id_t id;
        id = '{port_id: 1'b0, y: YWidth'(y), x: XWidth'(x)};
        return 32'({1'b1, id, XWidth'(mx), YWidth'(my), e});
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic send(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] m, input logic [31:0] e);
        in_valid_i = 1'b1;
        in_addr_i  = a;
        in_mask_i  = m;
        @(posedge clk_i); #1 in_valid_i = 1'b0;
        chk({tag, "_s1"}, 32'(out_valid_o), 32'd0);
        @(posedge clk_i); #1 chk(tag, obs(), e);
        @(posedge clk_i); #1;
    endtask

    task automatic burst(input string tag, input bit stall, output int first, output int last);
        logic [31:0] held;
        bit stalled;
        int sent, got;
        held = '0; stalled = 1'b0; sent = 0; got = 0; first = -1; last = -1;
        for (int c = 0; c < 60 && got < 8; c++) begin
            out_ready_i = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            in_valid_i  = sent < 8;
            in_addr_i   = AW'(32'h2000_0000) + AW'(sent) * AW'(32'h100);
            in_mask_i   = AW'(sent) << 18;
            #1;
            if (stalled) chk({tag, "_hold"}, obs(), held);
            if (out_valid_o && out_ready_i) begin
                chk({tag, "_data"}, obs(), ex(1, 0, En ? (got >> 2) & 3 : 0, En ? got & 3 : 0, ERR_OK));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            stalled = out_valid_o && !out_ready_i;
            held    = obs();
            if (in_valid_i && in_ready_o) sent++;
            @(posedge clk_i); #1;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk({tag, "_count"}, 32'(got), 32'd8);
        chk({tag, "_sent"}, 32'(sent), 32'd8);
        repeat (2) @(posedge clk_i);
        #1 chk({tag, "_drained"}, 32'(out_valid_o), 32'd0);
    endtask

    task automatic stream(input int n);
        in_addr_i  = AW'(32'h100);
        in_mask_i  = '0;
        in_valid_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out", obs(), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_cnt", 32'(err_cnt_o), 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        #1 chk("post_rst_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i); #1;

        send("a_mcast", AW'(32'h2000_1000), AW'(32'h0034_0000), ex(1, 0, En ? 3 : 0, En ? 1 : 0, ERR_OK));
        send("a_start_full", AW'(32'h2000_0000), '1, ex(1, 0, En ? 3 : 0, En ? 3 : 0, ERR_OK));
        send("b_uni", AW'(32'h7000_0040), '0, ex(0, 3, 0, 0, ERR_OK));
        chk("b_uni_cnt", 32'(err_cnt_o), 32'd0);
        send("b_illegal", AW'(32'h7000_0040), AW'(32'h10), ex(0, 3, 0, 0, En ? ERR_ILLEGAL_MCAST : ERR_OK));
        chk("b_illegal_cnt", 32'(err_cnt_o), En ? 32'd1 : 32'd0);
        send("c_nomatch", AW'(32'h100), '0, ex(0, 0, 0, 0, ERR_NO_MATCH));
        chk("c_nomatch_cnt", 32'(err_cnt_o), En ? 32'd2 : 32'd1);
        send("c_end0", AW'(32'h2004_0000), '0, ex(0, 0, 0, 0, ERR_NO_MATCH));
        send("c_last0", AW'(32'h2003_FFFF), AW'(32'h0010_0000), ex(1, 0, En ? 1 : 0, 0, ERR_OK));
        send("c_end1", AW'(32'h7010_0000), '0, ex(0, 0, 0, 0, ERR_NO_MATCH));
        chk("c_end_cnt", 32'(err_cnt_o), En ? 32'd4 : 32'd3);

        burst("stall", 1'b1, first_c, last_c);
        burst("tput", 1'b0, first_c, last_c);
        chk("tput_span", 32'(last_c - first_c), 32'd7);

        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_addr_i   = AW'(32'h100);
        @(posedge clk_i); #1 in_addr_i = AW'(32'h200);
        @(posedge clk_i); #1 in_valid_i = 1'b0;
        chk("mid_inflight", 32'(out_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1 chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(in_ready_o), 32'd1);
        chk("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        out_ready_i = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1 seen = seen | out_valid_o;
        end
        chk("mid_no_stale", 32'(seen), 32'd0);
        chk("mid_cnt_after", 32'(err_cnt_o), 32'd0);

        stream(6);
        chk("sat_minus1", 32'(err_cnt_o), 32'd6);
        stream(3);
        chk("sat_all_ones", 32'(err_cnt_o), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
